// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified instruction/data memory between the core's
// memory port and an external loader/debug port. Each transaction runs
// IDLE -> ISSUE -> (WAIT x MEM_LAT for reads) -> RESP -> IDLE.
//
// Handshake: a requester raises req with we/addr/wdata and holds them stable
// until it sees ack, which is a single-cycle pulse in the RESP cycle. For a
// read, rdata is valid in the ack cycle. It stays valid until that same
// requester's next read completes. Requests are only sampled in IDLE, so a
// req still high in the cycle after ack starts a new transaction.
module mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MEM_LAT        = 2,
    parameter int MAX_CORE_BURST = 4
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_ack,
    output logic              core_stall,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner,
    output logic [1:0]        dbg_state,
    output logic [3:0]        dbg_streak
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    localparam logic [3:0] LAT   = 4'(MEM_LAT);
    localparam logic [3:0] MAX_B = 4'(MAX_CORE_BURST);

    state_e              state_q;
    logic [3:0]          cnt_q;
    logic [3:0]          streak_q;
    logic [3:0]          streak_d;
    logic                pick_ldr_d;
    logic                owner_q;
    logic                busy_q;
    logic                mem_en_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W-1:0]   core_rdata_q;
    logic [DATA_W-1:0]   ldr_rdata_q;
    logic                core_ack_q;
    logic                ldr_ack_q;

    // Arbitration: the core wins unless it has used up its burst allowance
    // while the loader was waiting. The streak only counts core grants made
    // while the loader was also requesting.
    always_comb begin
        pick_ldr_d = ldr_req & (~core_req | (streak_q == MAX_B));
        streak_d   = '0;
        if (!pick_ldr_d && ldr_req) begin
            streak_d = (streak_q == MAX_B) ? streak_q : streak_q + 4'd1;
        end
    end

    // Transaction sequencer; all outputs are registered here.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            streak_q     <= '0;
            owner_q      <= 1'b0;
            busy_q       <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_rdata_q <= '0;
            ldr_rdata_q  <= '0;
            core_ack_q   <= 1'b0;
            ldr_ack_q    <= 1'b0;
        end else begin
            core_ack_q <= 1'b0;
            ldr_ack_q  <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (core_req || ldr_req) begin
                        owner_q     <= pick_ldr_d;
                        streak_q    <= streak_d;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= pick_ldr_d ? ldr_we    : core_we;
                        mem_addr_q  <= pick_ldr_d ? ldr_addr  : core_addr;
                        mem_wdata_q <= pick_ldr_d ? ldr_wdata : core_wdata;
                        busy_q      <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // mem_we_q still carries the latched direction this cycle.
                    if (mem_we_q) begin
                        core_ack_q <= ~owner_q;
                        ldr_ack_q  <= owner_q;
                        state_q    <= S_RESP;
                    end else begin
                        cnt_q   <= LAT;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        if (owner_q) ldr_rdata_q  <= mem_rdata;
                        else         core_rdata_q <= mem_rdata;
                        core_ack_q <= ~owner_q;
                        ldr_ack_q  <= owner_q;
                        state_q    <= S_RESP;
                    end
                end
                S_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign core_rdata = core_rdata_q;
    assign core_ack   = core_ack_q;
    assign core_stall = core_req & ~core_ack_q;
    assign ldr_rdata  = ldr_rdata_q;
    assign ldr_ack    = ldr_ack_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign owner      = owner_q;
    assign dbg_state  = state_q;
    assign dbg_streak = streak_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a table of single transactions on a MEM_LAT=2
// instance, then hand-written sequences for contention, burst fairness,
// reset mid-read and back-to-back reads on a MEM_LAT=1 instance.
`timescale 1ns/1ps
module tb_mem_arbiter;

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- DUT 0 (MEM_LAT=2) ----------------
    logic        core_req, core_we, core_ack, core_stall;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        ldr_req, ldr_we, ldr_ack;
    logic [31:0] ldr_addr, ldr_wdata, ldr_rdata;
    logic        mem_en, mem_we, busy, owner;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  dbg_state;
    logic [3:0]  dbg_streak;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .MAX_CORE_BURST(4)) u_dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_ack(core_ack), .core_stall(core_stall),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner),
        .dbg_state(dbg_state), .dbg_streak(dbg_streak)
    );

    // ---------------- DUT 1 (MEM_LAT=1), loader only ----------------
    logic        d1_core_req, d1_core_we, d1_core_ack, d1_core_stall;
    logic [31:0] d1_core_addr, d1_core_wdata, d1_core_rdata;
    logic        d1_ldr_req, d1_ldr_we, d1_ldr_ack;
    logic [31:0] d1_ldr_addr, d1_ldr_wdata, d1_ldr_rdata;
    logic        d1_mem_en, d1_mem_we, d1_busy, d1_owner;
    logic [31:0] d1_mem_addr, d1_mem_wdata, d1_mem_rdata;
    logic [1:0]  d1_dbg_state;
    logic [3:0]  d1_dbg_streak;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_CORE_BURST(4)) u_dut1 (
        .Clk(Clk), .Rst_n(Rst_n),
        .core_req(d1_core_req), .core_we(d1_core_we), .core_addr(d1_core_addr), .core_wdata(d1_core_wdata),
        .core_rdata(d1_core_rdata), .core_ack(d1_core_ack), .core_stall(d1_core_stall),
        .ldr_req(d1_ldr_req), .ldr_we(d1_ldr_we), .ldr_addr(d1_ldr_addr), .ldr_wdata(d1_ldr_wdata),
        .ldr_rdata(d1_ldr_rdata), .ldr_ack(d1_ldr_ack),
        .mem_en(d1_mem_en), .mem_we(d1_mem_we), .mem_addr(d1_mem_addr), .mem_wdata(d1_mem_wdata),
        .mem_rdata(d1_mem_rdata), .busy(d1_busy), .owner(d1_owner),
        .dbg_state(d1_dbg_state), .dbg_streak(d1_dbg_streak)
    );

    // ---------------- memory model ----------------
    // Read data is only valid exactly MEM_LAT cycles after the ISSUE cycle.
    logic [31:0] mem [0:255] = '{0: 32'h1111_1111, 1: 32'h2222_2222, 2: 32'h3333_3333,
                                 4: 32'hDEAD_BEEF, default: 32'h0};
    logic [3:0] lat0 = '0, lat1 = '0;
    logic [7:0] rd_addr0 = '0, rd_addr1 = '0;

    always @(posedge Clk) begin
        if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
        if (mem_en && !mem_we) begin
            lat0 <= 4'd1; rd_addr0 <= mem_addr[9:2];
        end else if (lat0 == 4'd2) lat0 <= 4'd0;
        else if (lat0 != 4'd0) lat0 <= lat0 + 4'd1;
    end

    always @(posedge Clk) begin
        if (d1_mem_en && !d1_mem_we) begin
            lat1 <= 4'd1; rd_addr1 <= d1_mem_addr[9:2];
        end else if (lat1 == 4'd1) lat1 <= 4'd0;
    end

    assign mem_rdata    = (lat0 == 4'd2) ? mem[rd_addr0] : 32'hBAD0_BAD0;
    assign d1_mem_rdata = (lat1 == 4'd1) ? mem[rd_addr1] : 32'hBAD0_BAD0;

    // ---------------- scoreboard ----------------
    int n_chk = 0;
    int n_fail = 0;
    int viol = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // At most one ack per cycle, and never together with mem_en.
    always @(negedge Clk) begin
        if (Rst_n) begin
            if ((core_ack && ldr_ack) || ((core_ack || ldr_ack) && mem_en)) viol++;
            if ((d1_core_ack && d1_ldr_ack) || ((d1_core_ack || d1_ldr_ack) && d1_mem_en)) viol++;
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        bit          ldr;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs [6];

    // ---------------- driver tasks ----------------
    task automatic do_txn(input vec_t v, input string tag);
        int ack_cyc;
        int en_cyc;
        int en_cnt;
        ack_cyc = -1; en_cyc = -1; en_cnt = 0;
        @(posedge Clk); #1;
        if (v.ldr) begin
            ldr_we = v.we; ldr_addr = v.addr; ldr_wdata = v.wdata; ldr_req = 1'b1;
        end else begin
            core_we = v.we; core_addr = v.addr; core_wdata = v.wdata; core_req = 1'b1;
        end
        for (int c = 0; c < 40 && ack_cyc < 0; c++) begin
            @(negedge Clk);
            if (!v.ldr && c == 0) chk({tag, " stall_t0"}, 32'(core_stall), 32'd1);
            if (mem_en) begin
                en_cnt++;
                if (en_cyc < 0) begin
                    en_cyc = c;
                    chk({tag, " mem_addr"}, mem_addr, v.addr);
                    chk({tag, " mem_we"}, 32'(mem_we), 32'(v.we));
                end
            end
            if (v.ldr ? ldr_ack : core_ack) begin
                ack_cyc = c;
                chk({tag, " owner"}, 32'(owner), 32'(v.ldr));
                if (!v.we) chk({tag, " rdata"}, v.ldr ? ldr_rdata : core_rdata, v.exp_rdata);
                if (!v.ldr) chk({tag, " stall_ack"}, 32'(core_stall), 32'd0);
            end
        end
        chk({tag, " ack_cycle"}, 32'(ack_cyc), 32'(v.exp_lat));
        chk({tag, " en_cycle"}, 32'(en_cyc), 32'd1);
        chk({tag, " en_count"}, 32'(en_cnt), 32'd1);
        @(posedge Clk); #1;
        core_req = 1'b0; ldr_req = 1'b0;
    endtask

    // ---------------- test ----------------
    initial begin
        logic [31:0] d1_exp [3];
        bit          exp_ldr_seq [10];
        int          cack, lack, n_ack, k, seen;
        bit          hit;

        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
        d1_core_req = 0; d1_core_we = 0; d1_core_addr = 0; d1_core_wdata = 0;
        d1_ldr_req = 0; d1_ldr_we = 0; d1_ldr_addr = 0; d1_ldr_wdata = 0;

        vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,          32'hDEAD_BEEF, 4};
        vecs[1] = '{1'b1, 1'b1, 32'h20, 32'h1234_5678,  32'h0,         2};
        vecs[2] = '{1'b0, 1'b0, 32'h20, 32'h0,          32'h1234_5678, 4};
        vecs[3] = '{1'b0, 1'b1, 32'h24, 32'hA5A5_A5A5,  32'h0,         2};
        vecs[4] = '{1'b1, 1'b0, 32'h24, 32'h0,          32'hA5A5_A5A5, 4};
        vecs[5] = '{1'b1, 1'b0, 32'h10, 32'h0,          32'hDEAD_BEEF, 4};

        // Reset values
        #23;
        chk("rst core_rdata", core_rdata, 32'h0);
        chk("rst ldr_rdata", ldr_rdata, 32'h0);
        chk("rst acks", {30'd0, core_ack, ldr_ack}, 32'h0);
        chk("rst mem_en_we", {30'd0, mem_en, mem_we}, 32'h0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst mem_wdata", mem_wdata, 32'h0);
        chk("rst busy_owner", {30'd0, busy, owner}, 32'h0);
        chk("rst state_streak", {26'd0, dbg_state, dbg_streak}, 32'h0);
        @(negedge Clk); Rst_n = 1'b1;

        // Single transactions from the table
        for (int i = 0; i < 6; i++) do_txn(vecs[i], $sformatf("vec%0d", i));
        chk("core_rdata held", core_rdata, 32'h1234_5678);

        // Simultaneous requests: core first, loader after one IDLE cycle
        @(posedge Clk); #1;
        core_we = 0; core_addr = 32'h10; ldr_we = 0; ldr_addr = 32'h20;
        core_req = 1; ldr_req = 1;
        cack = -1; lack = -1;
        for (int c = 0; c < 40 && lack < 0; c++) begin
            @(negedge Clk);
            if (c == 1) chk("both first_owner", 32'(owner), 32'd0);
            if (core_ack && cack < 0) cack = c;
            if (ldr_ack && lack < 0) begin
                lack = c;
                chk("both streak_after_ldr", 32'(dbg_streak), 32'd0);
            end
            @(posedge Clk); #1;
            if (cack >= 0) core_req = 0;
            if (lack >= 0) ldr_req = 0;
        end
        core_req = 0; ldr_req = 0;
        chk("both core_ack_cycle", 32'(cack), 32'd4);
        chk("both ldr_ack_cycle", 32'(lack), 32'd9);
        chk("both core_rdata", core_rdata, 32'hDEAD_BEEF);
        chk("both ldr_rdata", ldr_rdata, 32'h1234_5678);

        // Continuous contention with writes: 4 core grants then 1 loader grant
        for (int i = 0; i < 10; i++) exp_ldr_seq[i] = (i == 4 || i == 9);
        @(posedge Clk); #1;
        core_we = 1; core_addr = 32'h40; core_wdata = 32'hC0C0_0001;
        ldr_we = 1;  ldr_addr = 32'h44;  ldr_wdata = 32'h1D1D_0002;
        core_req = 1; ldr_req = 1;
        n_ack = 0;
        for (int c = 0; c < 200 && n_ack < 10; c++) begin
            @(negedge Clk);
            if (core_ack || ldr_ack) begin
                chk($sformatf("burst grant%0d is_ldr", n_ack), 32'(ldr_ack), 32'(exp_ldr_seq[n_ack]));
                chk($sformatf("burst grant%0d cycle", n_ack), 32'(c), 32'(2 + 3 * n_ack));
                if (ldr_ack) chk($sformatf("burst grant%0d streak", n_ack), 32'(dbg_streak), 32'd0);
                n_ack++;
            end
            @(posedge Clk); #1;
            if (n_ack >= 10) begin core_req = 0; ldr_req = 0; end
        end
        core_req = 0; ldr_req = 0;
        chk("burst ack_total", 32'(n_ack), 32'd10);

        // Reset in the middle of a core read's WAIT phase
        @(posedge Clk); #1;
        core_we = 0; core_addr = 32'h10; core_req = 1;
        repeat (3) @(negedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        chk("midrst core_rdata", core_rdata, 32'h0);
        chk("midrst ldr_rdata", ldr_rdata, 32'h0);
        chk("midrst ctrl", {27'd0, busy, owner, mem_en, core_ack, ldr_ack}, 32'h0);
        chk("midrst mem_addr", mem_addr, 32'h0);
        chk("midrst mem_wdata", mem_wdata, 32'h0);
        chk("midrst state", 32'(dbg_state), 32'd0);
        core_req = 0;
        @(negedge Clk); Rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge Clk);
            if (core_ack) seen++;
        end
        chk("midrst no_ack", 32'(seen), 32'd0);
        chk("midrst idle_after", {30'd0, dbg_state}, 32'h0);
        do_txn(vecs[0], "post_rst_read");

        // MEM_LAT=1 instance: loader reads 0x0, 0x4, 0x8 back to back
        d1_exp[0] = 32'h1111_1111; d1_exp[1] = 32'h2222_2222; d1_exp[2] = 32'h3333_3333;
        @(posedge Clk); #1;
        d1_ldr_we = 0; d1_ldr_addr = 32'h0; d1_ldr_req = 1;
        k = 0;
        for (int c = 0; c < 60 && k < 3; c++) begin
            @(negedge Clk);
            hit = d1_ldr_ack;
            if (hit) begin
                chk($sformatf("lat1 read%0d cycle", k), 32'(c), 32'(3 + 4 * k));
                chk($sformatf("lat1 read%0d rdata", k), d1_ldr_rdata, d1_exp[k]);
                k++;
            end
            @(posedge Clk); #1;
            if (hit) begin
                if (k >= 3) d1_ldr_req = 0;
                else d1_ldr_addr = 32'(4 * k);
            end
        end
        d1_ldr_req = 0;
        chk("lat1 ack_total", 32'(k), 32'd3);

        chk("ack_exclusive", 32'(viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
